// File: rtl/matmul_job_sched.sv
// Job scheduler for one matmul engine: buffers host descriptors in a small FIFO,
// launches them one at a time with a go pulse and reports completions.
module matmul_job_sched #(
  parameter int MEM_AW   = 16,
  parameter int DIM_BITS = 16,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [MEM_AW-1:0]   push_aBASE,
  input  logic [MEM_AW-1:0]   push_bBASE,
  input  logic [MEM_AW-1:0]   push_cBASE,
  input  logic [DIM_BITS-1:0] push_aSTRIDE,
  input  logic [DIM_BITS-1:0] push_bSTRIDE,
  input  logic [DIM_BITS-1:0] push_cSTRIDE,
  input  logic [DIM_BITS-1:0] push_aROWS,
  input  logic [DIM_BITS-1:0] push_aCOLS,
  input  logic [DIM_BITS-1:0] push_bCOLS,
  input  logic                flush,
  output logic [MEM_AW-1:0]   aBASE,
  output logic [MEM_AW-1:0]   bBASE,
  output logic [MEM_AW-1:0]   cBASE,
  output logic [DIM_BITS-1:0] aSTRIDE,
  output logic [DIM_BITS-1:0] bSTRIDE,
  output logic [DIM_BITS-1:0] cSTRIDE,
  output logic [DIM_BITS-1:0] aROWS,
  output logic [DIM_BITS-1:0] aCOLS,
  output logic [DIM_BITS-1:0] bCOLS,
  output logic                go,
  input  logic                ret,
  output logic                job_done,
  output logic [CNT_W-1:0]    done_cnt,
  output logic [PTR_W:0]      q_level,
  output logic                busy
);

  typedef struct packed {
    logic [MEM_AW-1:0]   a_base;
    logic [MEM_AW-1:0]   b_base;
    logic [MEM_AW-1:0]   c_base;
    logic [DIM_BITS-1:0] a_stride;
    logic [DIM_BITS-1:0] b_stride;
    logic [DIM_BITS-1:0] c_stride;
    logic [DIM_BITS-1:0] a_rows;
    logic [DIM_BITS-1:0] a_cols;
    logic [DIM_BITS-1:0] b_cols;
  } desc_t;

  typedef enum logic [2:0] {IDLE, GO, RUN, GAP, SKIP} state_t;

  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  state_t           state;
  desc_t            mem [DEPTH];
  desc_t            prm, head, push_desc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   lvl_nxt;
  logic             ready_q, push_fire, pop, gap_cnt;

  assign push_desc = '{push_aBASE, push_bBASE, push_cBASE,
                       push_aSTRIDE, push_bSTRIDE, push_cSTRIDE,
                       push_aROWS, push_aCOLS, push_bCOLS};
  assign push_ready = ready_q & ~flush;
  assign push_fire  = push_valid & push_ready;
  assign pop        = (state == IDLE) && (q_level != '0);
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || (q_level != '0);

  assign aBASE   = prm.a_base;
  assign bBASE   = prm.b_base;
  assign cBASE   = prm.c_base;
  assign aSTRIDE = prm.a_stride;
  assign bSTRIDE = prm.b_stride;
  assign cSTRIDE = prm.c_stride;
  assign aROWS   = prm.a_rows;
  assign aCOLS   = prm.a_cols;
  assign bCOLS   = prm.b_cols;

  // Flush never coincides with a push, so dropping to zero covers a same-cycle pop too.
  always_comb begin
    lvl_nxt = q_level;
    if (flush)                  lvl_nxt = '0;
    else if (push_fire && !pop) lvl_nxt = q_level + (PTR_W+1)'(1);
    else if (!push_fire && pop) lvl_nxt = q_level - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_desc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (flush)     rd_ptr <= wr_ptr;
      else if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_level <= lvl_nxt;
      ready_q <= (lvl_nxt != LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prm      <= '0;
      go       <= 1'b0;
      job_done <= 1'b0;
      done_cnt <= '0;
      gap_cnt  <= 1'b0;
    end else begin
      go       <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          prm <= head;
          if (head.a_rows == '0 || head.b_cols == '0) begin
            state    <= SKIP;
            job_done <= 1'b1;
            done_cnt <= done_cnt + CNT_W'(1);
          end else begin
            state <= GO;
            go    <= 1'b1;
          end
        end
        GO:   state <= RUN;
        RUN:  if (ret) begin
          state    <= GAP;
          job_done <= 1'b1;
          done_cnt <= done_cnt + CNT_W'(1);
          gap_cnt  <= 1'b0;
        end
        // Two idle cycles let the engine settle back into its go-wait loop.
        GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) state <= IDLE;
        end
        SKIP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
